// File: rtl/store_buffer.sv
// In-order store buffer between the core store port and the wishbone store unit; optional load-hazard compare under STORE_BUFFER_HAZARD_EN.
// Latency: a pushed store reaches the head outputs the next cycle; a pop on valid_i shows the next head the next cycle.
// Backpressure: st_ready_o drops while DEPTH entries are pending, and a pop in the same cycle does not lift it.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        st_req_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  st_size_i,
    output logic        st_ready_o,
    output logic        st_err_o,
    output logic        empty_o,
    input  logic [31:0] ld_addr_i,
    output logic        ld_hit_o,
    output logic        write_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  we_o,
    input  logic        valid_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [3:0]    mem_we   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          legal;
    logic [3:0]    al_we;
    logic [31:0]   al_data;
    logic          push;
    logic          pop;
    logic          err_q;

    // Byte lane placement and legality of the incoming request.
    always_comb begin
        legal   = 1'b0;
        al_we   = 4'b0000;
        al_data = st_data_i;
        case (st_size_i)
            2'b00: begin
                legal   = 1'b1;
                al_we   = 4'b0001 << st_addr_i[1:0];
                al_data = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                legal   = ~st_addr_i[0];
                al_we   = 4'b0011 << st_addr_i[1:0];
                al_data = {2{st_data_i[15:0]}};
            end
            2'b10: begin
                legal   = (st_addr_i[1:0] == 2'b00);
                al_we   = 4'b1111;
                al_data = st_data_i;
            end
            default: begin
                legal   = 1'b0;
                al_we   = 4'b0000;
                al_data = st_data_i;
            end
        endcase
    end

    assign st_ready_o = (count != CW'(DEPTH));
    assign push       = st_req_i && st_ready_o && legal;
    assign pop        = valid_i && (count != '0);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= st_req_i && st_ready_o && !legal;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage needs no reset: contents are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= st_addr_i[31:2];
            mem_data[wr_ptr] <= al_data;
            mem_we[wr_ptr]   <= al_we;
        end
    end

    assign st_err_o = err_q;
    assign empty_o  = (count == '0);
    assign write_o  = !empty_o;
    assign addr_o   = write_o ? {mem_addr[rd_ptr], 2'b00} : 32'h0;
    assign data_o   = write_o ? mem_data[rd_ptr] : 32'h0;
    assign we_o     = write_o ? mem_we[rd_ptr] : 4'h0;

`ifdef STORE_BUFFER_HAZARD_EN
    logic          hit;
    logic [PW-1:0] rel;
    logic [1:0]    unused_ld;

    // An entry is live when its distance from the head is below count.
    always_comb begin
        hit = 1'b0;
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PW'(i) - rd_ptr;
            if (({1'b0, rel} < count) && (mem_addr[i] == ld_addr_i[31:2]))
                hit = 1'b1;
        end
    end

    assign ld_hit_o  = hit;
    assign unused_ld = ld_addr_i[1:0];
`else
    logic [31:0] unused_ld;

    assign ld_hit_o  = 1'b0;
    assign unused_ld = ld_addr_i;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: alignment, errors, full backpressure, streaming wrap, hazard and async reset.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rstn_i;
    logic        st_req_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic [1:0]  st_size_i;
    logic        st_ready_o;
    logic        st_err_o;
    logic        empty_o;
    logic [31:0] ld_addr_i;
    logic        ld_hit_o;
    logic        write_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [3:0]  we_o;
    logic        valid_i;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    logic hz_exp;

    store_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .st_req_i   (st_req_i),
        .st_addr_i  (st_addr_i),
        .st_data_i  (st_data_i),
        .st_size_i  (st_size_i),
        .st_ready_o (st_ready_o),
        .st_err_o   (st_err_o),
        .empty_o    (empty_o),
        .ld_addr_i  (ld_addr_i),
        .ld_hit_o   (ld_hit_o),
        .write_o    (write_o),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .we_o       (we_o),
        .valid_i    (valid_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_req_i  = 1'b1;
        st_addr_i = a;
        st_data_i = d;
        st_size_i = s;
        tick();
        st_req_i  = 1'b0;
    endtask

    task automatic pop_one();
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
`ifdef STORE_BUFFER_HAZARD_EN
        hz_exp = 1'b1;
`else
        hz_exp = 1'b0;
`endif
        rstn_i    = 1'b0;
        st_req_i  = 1'b0;
        st_addr_i = 32'h0;
        st_data_i = 32'h0;
        st_size_i = 2'b00;
        ld_addr_i = 32'h0;
        valid_i   = 1'b0;
        #12;
        rstn_i = 1'b1;
        tick();

        // Reset state
        check("rst_ready", 32'(st_ready_o), 32'd1);
        check("rst_err",   32'(st_err_o),   32'd0);
        check("rst_empty", 32'(empty_o),    32'd1);
        check("rst_write", 32'(write_o),    32'd0);
        check("rst_addr",  addr_o,          32'h0);
        check("rst_data",  data_o,          32'h0);
        check("rst_we",    32'(we_o),       32'h0);
        check("rst_hit",   32'(ld_hit_o),   32'd0);

        // Byte store at 0x1003 lands in lane 3
        push_store(32'h1003, 32'h0000_00A5, 2'b00);
        check("byte_write", 32'(write_o), 32'd1);
        check("byte_addr",  addr_o,       32'h1000);
        check("byte_we",    32'(we_o),    32'h8);
        check("byte_data",  data_o,       32'hA5A5_A5A5);
        check("byte_empty", 32'(empty_o), 32'd0);
        pop_one();
        check("byte_pop_empty", 32'(empty_o), 32'd1);
        check("byte_pop_write", 32'(write_o), 32'd0);

        // Half store at 0x4002 goes to upper lanes
        push_store(32'h4002, 32'h0000_1234, 2'b01);
        check("half_we",   32'(we_o), 32'hC);
        check("half_data", data_o,    32'h1234_1234);
        pop_one();

        // Misaligned half and illegal size are rejected with a one-cycle error
        push_store(32'h2001, 32'h0, 2'b01);
        check("mis_err",   32'(st_err_o), 32'd1);
        check("mis_empty", 32'(empty_o),  32'd1);
        tick();
        check("mis_err_clr", 32'(st_err_o), 32'd0);
        push_store(32'h2000, 32'h0, 2'b11);
        check("ill_err",   32'(st_err_o), 32'd1);
        check("ill_empty", 32'(empty_o),  32'd1);
        tick();
        check("ill_err_clr", 32'(st_err_o), 32'd0);
        push_store(32'h2002, 32'h0, 2'b10);
        check("misw_err", 32'(st_err_o), 32'd1);
        tick();

        // Fill to DEPTH, fifth held off, pop frees one slot
        for (int i = 0; i < 4; i++) push_store(32'h100 + 32'(4 * i), 32'(i), 2'b10);
        check("full_ready", 32'(st_ready_o), 32'd0);
        st_req_i  = 1'b1;
        st_addr_i = 32'h110;
        st_data_i = 32'd4;
        st_size_i = 2'b10;
        tick();
        check("full_hold_ready", 32'(st_ready_o), 32'd0);
        check("full_head",       addr_o,          32'h100);
        check("full_no_err",     32'(st_err_o),   32'd0);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("full_ready_back", 32'(st_ready_o), 32'd1);
        check("full_head2",      addr_o,          32'h104);
        tick();
        st_req_i = 1'b0;
        check("full_refill", 32'(st_ready_o), 32'd0);
        for (int i = 1; i < 5; i++) begin
            check("full_order", addr_o, 32'h100 + 32'(4 * i));
            check("full_odata", data_o, 32'(i));
            pop_one();
        end
        check("drain_empty", 32'(empty_o), 32'd1);
        pop_one();
        check("pop_empty_ignored", 32'(empty_o), 32'd1);
        check("pop_empty_write",   32'(write_o), 32'd0);

        // Streaming push+pop every cycle, wrapping the pointers
        push_store(32'h200, 32'd0, 2'b10);
        for (int k = 1; k < 7; k++) begin
            st_req_i  = 1'b1;
            st_addr_i = 32'h200 + 32'(4 * k);
            st_data_i = 32'(k);
            st_size_i = 2'b10;
            valid_i   = 1'b1;
            tick();
            check("str_write", 32'(write_o), 32'd1);
            check("str_addr",  addr_o,       32'h200 + 32'(4 * k));
            check("str_data",  data_o,       32'(k));
            check("str_ready", 32'(st_ready_o), 32'd1);
        end
        st_req_i = 1'b0;
        tick();
        valid_i = 1'b0;
        check("str_drain", 32'(empty_o), 32'd1);

        // Load hazard against a pending word store
        ld_addr_i = 32'h3006;
        st_req_i  = 1'b1;
        st_addr_i = 32'h3004;
        st_data_i = 32'h55;
        st_size_i = 2'b10;
        #1;
        check("hz_push_cycle", 32'(ld_hit_o), 32'd0);
        tick();
        st_req_i = 1'b0;
        check("hz_hit", 32'(ld_hit_o), 32'(hz_exp));
        ld_addr_i = 32'h3008;
        #1;
        check("hz_other_word", 32'(ld_hit_o), 32'd0);
        ld_addr_i = 32'h3006;
        pop_one();
        check("hz_after_pop", 32'(ld_hit_o), 32'd0);

        // Asynchronous reset with three entries pending
        for (int i = 0; i < 3; i++) push_store(32'h500 + 32'(4 * i), 32'(i), 2'b10);
        check("ar_pre_write", 32'(write_o), 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("ar_write", 32'(write_o),    32'd0);
        check("ar_empty", 32'(empty_o),    32'd1);
        check("ar_ready", 32'(st_ready_o), 32'd1);
        tick();
        rstn_i = 1'b1;
        tick();
        tick();
        check("ar_post_empty", 32'(empty_o), 32'd1);
        check("ar_post_write", 32'(write_o), 32'd0);
        check("ar_post_addr",  addr_o,       32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Buffers core store requests ahead of the wishbone store unit so the pipeline can retire stores without waiting for bus acknowledge. Each accepted store is aligned to its 32-bit word, given byte enables, and pushed into a small in-order FIFO. The head entry drives the store unit's `write`/`addr`/`data`/`we` inputs and is popped on the store unit's `valid` pulse.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- clk  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- st_req_i  in  1  core store request, qualified by st_ready_o
- st_addr_i  in  32  byte address of store
- st_data_i  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- st_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- st_ready_o  out  1  buffer can accept a request this cycle
- st_err_o  out  1  one-cycle pulse: request rejected (misaligned or illegal size)
- empty_o  out  1  no stores pending (fence/drain indication)
- ld_addr_i  in  32  load address for hazard check
- ld_hit_o  out  1  a pending store targets the same word as ld_addr_i
- write_o  out  1  to store unit write_i; high while an entry is pending
- addr_o  out  32  to store unit addr_i; head word address, [1:0]=00
- data_o  out  32  to store unit data_i; head aligned data
- we_o  out  4  to store unit we_i; head byte enables
- valid_i  in  1  from store unit valid_o; head store acknowledged

## Operation
- Storage: DEPTH entries of {addr[31:2], data[31:0], we[3:0]}; write pointer, read pointer, count of width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- st_ready_o = (count != DEPTH). No full-bypass: when full, ready stays 0 even if a pop occurs that cycle.
- Accept: st_req_i && st_ready_o && legal → push. Illegal (size 11, half with addr[0]=1, word with addr[1:0]≠00) → not pushed, st_err_o pulses next cycle; regardless of ready? No: error only reported when st_ready_o=1 (request is consumed).
- Alignment, o = addr[1:0]: byte → we = 4'b0001<<o, data = {4{d[7:0]}}; half → we = 4'b0011<<o, data = {2{d[15:0]}}; word → we = 4'b1111, data = d.
- Pop: valid_i && count≠0 → read pointer advances. valid_i with count=0 is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- write_o = (count≠0); addr_o/data_o/we_o driven combinationally from head entry, 0 when empty. write_o stays high across back-to-back entries so the store unit remains in its write state.
- empty_o = (count==0).

## Timing
- Reset values: st_ready_o=1, st_err_o=0, empty_o=1, write_o=0, addr_o/data_o/we_o=0, ld_hit_o=0; pointers and count 0.
- Push in cycle N into empty buffer → write_o=1 and head fields valid in cycle N+1.
- Pop on valid_i in cycle N → next head (or write_o=0) visible in cycle N+1.
- st_err_o registered, asserted exactly cycle N+1 for a rejected request in N, single cycle.
- Reset mid-operation: all entries discarded immediately (asynchronous); write_o drops with rstn_i.

## Configuration
- STORE_BUFFER_HAZARD_EN defined: ld_hit_o = OR over valid entries of (entry.addr[31:2] == ld_addr_i[31:2]), combinational, includes head; excludes entries in the cycle they are pushed.
- Undefined: compare logic removed, ld_hit_o tied 0; ld_addr_i ignored. Ports exist in both builds.

## Test plan
- Reset, then byte store addr 0x1003 data 0xA5 → next cycle write_o=1, addr_o=0x1000, we_o=4'b1000, data_o=0xA5A5A5A5, empty_o=0.
- Half store addr 0x2001 → no push, st_err_o=1 for one cycle, empty_o stays 1; size 11 at 0x2000 → same.
- Five word stores with valid_i held 0 (DEPTH=4) → four accepted, st_ready_o=0 after fourth, fifth held off; pulse valid_i → ready returns next cycle, order of addr_o preserved.
- valid_i asserted every cycle while pushing one store per cycle → count constant, write_o continuously high, entries emerge in order through pointer wrap.
- HAZARD_EN: pending store to 0x3004, ld_addr_i=0x3006 → ld_hit_o=1; after its valid_i pop → ld_hit_o=0; without macro → ld_hit_o=0 always.
- Assert rstn_i low with three entries pending → write_o=0, empty_o=1, st_ready_o=1 immediately; no stale entry after release.
